// File: rtl/logica_comb_de_salida_pkg.sv
// Shared definitions for the two-pump alternating controller.
// The y encoding is shared with the state-register and next-state blocks.
package logica_comb_de_salida_pkg;

    // State bit encoding: whose turn it is to run alone under normal demand
    localparam logic TURNO_B1 = 1'b0;
    localparam logic TURNO_B2 = 1'b1;

    // Pump enable pair, b1 in the MSB
    typedef struct packed {
        logic b1;
        logic b2;
    } bombas_t;

endpackage

// File: rtl/logica_comb_de_salida_if.sv
// Bus between the controller FSM and the output logic.
// The FSM side (master) drives the request, sensor and state bit.
// The output logic (slave) returns the two pump enables.
interface logica_comb_de_salida_if;

    logic I;   // pump request
    logic S;   // overload / high-level sensor
    logic y;   // state bit: TURNO_B1 or TURNO_B2
    logic B1;  // pump 1 enable
    logic B2;  // pump 2 enable

    modport master (
        output I,
        output S,
        output y,
        input  B1,
        input  B2
    );

    modport slave (
        input  I,
        input  S,
        input  y,
        output B1,
        output B2
    );

endinterface

// File: rtl/logica_comb_de_salida.sv
// Output logic of the two-pump alternating controller (Mealy).
// Decodes request, overload sensor and turn bit into the two pump enables.
// The outputs are combinational, or registered when REG_OUT is 1.
module logica_comb_de_salida
    import logica_comb_de_salida_pkg::*;
#(
    parameter bit REG_OUT = 1'b0
) (
    input logic                    clk,
    input logic                    rst_n,
    logica_comb_de_salida_if.slave bus
);

    bombas_t eq_val;

    // The request gates both pumps; overload turns both on; otherwise y picks the pump.
    always_comb begin
        eq_val.b1 = bus.I & ((bus.y == TURNO_B1) | bus.S);
        eq_val.b2 = bus.I & ((bus.y == TURNO_B2) | bus.S);
    end

    generate
        if (REG_OUT) begin : g_reg
            bombas_t out_q;

            // Output register. The asynchronous clear means reset needs no clock edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q <= '0;
                end else begin
                    out_q <= eq_val;
                end
            end

            assign bus.B1 = out_q.b1;
            assign bus.B2 = out_q.b2;
        end else begin : g_comb
            // clk has no use in the combinational mode
            logic unused_clk;
            assign unused_clk = clk;

            // rst_n masks the outputs directly, so reset still acts at once without a register
            assign bus.B1 = rst_n & eq_val.b1;
            assign bus.B2 = rst_n & eq_val.b2;
        end
    endgenerate

endmodule

// File: tb/tb_logica_comb_de_salida.sv
// Self-checking bench for logica_comb_de_salida.
// Both variants run side by side from the same stimulus: combinational and registered.
module tb_logica_comb_de_salida;

    logic clk;
    logic rst_n;

    logica_comb_de_salida_if bus_c ();
    logica_comb_de_salida_if bus_r ();

    logica_comb_de_salida #(.REG_OUT(1'b0)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_c)
    );

    logica_comb_de_salida #(.REG_OUT(1'b1)) dut_r (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_r)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0] q_c[$];
    logic [1:0] q_r[$];
    logic [1:0] last_r;  // value the registered variant is expected to hold

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference from the truth table: {B1, B2}
    function automatic logic [1:0] model(input logic i, input logic s, input logic y);
        if (!i)     return 2'b00;
        else if (s) return 2'b11;
        else if (y) return 2'b01;
        else        return 2'b10;
    endfunction

    task automatic drive(input logic i, input logic s, input logic y);
        bus_c.I = i; bus_c.S = s; bus_c.y = y;
        bus_r.I = i; bus_r.S = s; bus_r.y = y;
    endtask

    task automatic check_c(input string tag);
        logic [1:0] exp_v;
        logic [1:0] obs;
        exp_v = q_c.pop_front();
        obs = {bus_c.B1, bus_c.B2};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL comb %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic check_r(input string tag);
        logic [1:0] exp_v;
        logic [1:0] obs;
        exp_v = q_r.pop_front();
        obs = {bus_r.B1, bus_r.B2};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL reg %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Drive mid-cycle. The comb output must follow at once.
    // The registered output must hold its value until the next rising edge.
    task automatic step(input logic i, input logic s, input logic y, input string tag);
        @(negedge clk);
        drive(i, s, y);
        q_c.push_back(model(i, s, y));
        q_r.push_back(last_r);
        #1;
        check_c(tag);
        check_r({tag, "_hold"});
        last_r = model(i, s, y);
        q_r.push_back(last_r);
        @(posedge clk);
        #1;
        check_r({tag, "_upd"});
    endtask

    initial begin
        // Reset held with a live request: both variants must stay at 00
        rst_n  = 1'b0;
        last_r = 2'b00;
        drive(1'b1, 1'b1, 1'b0);
        #2;
        q_c.push_back(2'b00);
        q_r.push_back(2'b00);
        check_c("reset");
        check_r("reset");
        @(posedge clk);
        #1;
        q_r.push_back(2'b00);
        check_r("reset_edge");

        // Release: comb restores at once, reg waits for the first rising edge
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        q_c.push_back(2'b11);
        q_r.push_back(2'b00);
        check_c("release");
        check_r("release_hold");
        @(posedge clk);
        #1;
        last_r = 2'b11;
        q_r.push_back(last_r);
        check_r("release_upd");

        // Sweep all 8 input combinations
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = k[2:0];
            step(v[2], v[1], v[0], $sformatf("sweep%0d", k));
        end

        // With no request both pumps are off, whatever S and y are
        step(1'b0, 1'b1, 1'b1, "no_req");

        // Normal demand alternates with y
        step(1'b1, 1'b0, 1'b0, "alt_y0");
        step(1'b1, 1'b0, 1'b1, "alt_y1");
        step(1'b1, 1'b0, 1'b0, "alt_y0b");

        // Overload turns both pumps on for either y
        step(1'b1, 1'b1, 1'b0, "ovl_y0");
        step(1'b1, 1'b1, 1'b1, "ovl_y1");

        // Reset between clock edges while both pumps are on
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q_c.push_back(2'b00);
        q_r.push_back(2'b00);
        check_c("midrst");
        check_r("midrst");
        last_r = 2'b00;
        rst_n = 1'b1;
        #1;
        q_c.push_back(2'b11);
        q_r.push_back(2'b00);
        check_c("midrst_rel");
        check_r("midrst_rel_hold");
        @(posedge clk);
        #1;
        last_r = 2'b11;
        q_r.push_back(last_r);
        check_r("midrst_rel_upd");

        // Mid-cycle change to 1,0,1: reg holds 11 until the edge, then reads 01
        step(1'b1, 1'b0, 1'b1, "late_chg");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
